// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode-stage controls and operands for the execute stage.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            ValidD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            BranchD,
  input  logic            JumpD,
  input  logic            ALUSrcD,
  input  logic            loadD,
  input  logic            jarlD,
  input  logic [1:0]      ResultSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            JumpE,
  output logic            ALUSrcE,
  output logic            loadE,
  output logic            jarlE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            ValidE
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [31:0]     BubbleCntE
`endif
);

  // Control bits grouped so bubbles can clear them in one assignment.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic       load;
    logic       jarl;
    logic [1:0] result_src;
    logic [2:0] alu_control;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } data_t;

  ctrl_t ctrl_q, ctrl_d, ctrl_in;
  data_t data_q, data_d, data_in;
  logic  valid_q, valid_d;

  assign ctrl_in = '{reg_write: RegWriteD, mem_write: MemWriteD, branch: BranchD,
                     jump: JumpD, alu_src: ALUSrcD, load: loadD, jarl: jarlD,
                     result_src: ResultSrcD, alu_control: ALUControlD};
  assign data_in = '{rd1: RD1D, rd2: RD2D, pc: PCD, imm_ext: ImmExtD,
                     pc_plus4: PCPlus4D, rs1: Rs1D, rs2: Rs2D, rd: RdD};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (FlushE) begin
      ctrl_d  = '0;
      data_d  = '0;
      valid_d = 1'b0;
    end else if (!StallE) begin
      // The ternary selects a clean zero even if the decoder drives X on an invalid slot.
      ctrl_d  = ValidD ? ctrl_in : '0;
      valid_d = ValidD ? 1'b1 : 1'b0;
      data_d  = data_in;
      if (RdD == 5'd0) ctrl_d.reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      ctrl_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic        bubble_in;

  assign bubble_in = FlushE | (!StallE & !ValidD);

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_in && (bubble_cnt_q != 32'hFFFF_FFFF)) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) bubble_cnt_q <= '0;
    else       bubble_cnt_q <= bubble_cnt_d;
  end

  assign BubbleCntE = bubble_cnt_q;
`endif

  assign RegWriteE   = ctrl_q.reg_write;
  assign MemWriteE   = ctrl_q.mem_write;
  assign BranchE     = ctrl_q.branch;
  assign JumpE       = ctrl_q.jump;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign loadE       = ctrl_q.load;
  assign jarlE       = ctrl_q.jarl;
  assign ResultSrcE  = ctrl_q.result_src;
  assign ALUControlE = ctrl_q.alu_control;
  assign RD1E        = data_q.rd1;
  assign RD2E        = data_q.rd2;
  assign PCE         = data_q.pc;
  assign ImmExtE     = data_q.imm_ext;
  assign PCPlus4E    = data_q.pc_plus4;
  assign Rs1E        = data_q.rs1;
  assign Rs2E        = data_q.rs2;
  assign RdE         = data_q.rd;
  assign ValidE      = valid_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios plus randomized traffic against a
// slot-level reference model. Define ID_EX_BUBBLE_CNT_EN to also check the bubble counter.
module tb_id_ex_reg;

  typedef struct packed {
    logic        regwrite, memwrite, branch, jump, alusrc, load, jarl;
    logic [1:0]  resultsrc;
    logic [2:0]  aluctl;
    logic [31:0] rd1, rd2, pc, imm, pcp4;
    logic [4:0]  rs1, rs2, rd;
    logic        valid;
  } slot_t;

  localparam slot_t CTRL_MASK = '{regwrite: 1'b1, memwrite: 1'b1, branch: 1'b1, jump: 1'b1,
                                  alusrc: 1'b1, load: 1'b1, jarl: 1'b1, resultsrc: 2'b11,
                                  aluctl: 3'b111, default: '0};

  logic  clk = 1'b0;
  logic  reset, stall, flush;
  slot_t din;
  slot_t obs;
  slot_t exp_slot;
  int unsigned exp_cnt;
  int vectors = 0;
  int miscompares = 0;

  logic        RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, loadE, jarlE, ValidE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] BubbleCntE;
`endif

  always #5 clk = ~clk;

  id_ex_reg #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .StallE(stall), .FlushE(flush), .ValidD(din.valid),
    .RegWriteD(din.regwrite), .MemWriteD(din.memwrite), .BranchD(din.branch),
    .JumpD(din.jump), .ALUSrcD(din.alusrc), .loadD(din.load), .jarlD(din.jarl),
    .ResultSrcD(din.resultsrc), .ALUControlD(din.aluctl),
    .RD1D(din.rd1), .RD2D(din.rd2), .PCD(din.pc), .ImmExtD(din.imm), .PCPlus4D(din.pcp4),
    .Rs1D(din.rs1), .Rs2D(din.rs2), .RdD(din.rd),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
    .ALUSrcE(ALUSrcE), .loadE(loadE), .jarlE(jarlE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE),
    .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE)
`ifdef ID_EX_BUBBLE_CNT_EN
    , .BubbleCntE(BubbleCntE)
`endif
  );

  assign obs = {RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, loadE, jarlE, ResultSrcE,
                ALUControlE, RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE};

  function automatic slot_t rand_slot();
    slot_t s;
    s = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    s.valid = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 7) == 0) s.rd = 5'd0;
    return s;
  endfunction

  // Reference: what the EX slot should hold after one edge, from the slot rules.
  task automatic step(input logic r, input logic st, input logic fl);
    slot_t nxt;
    reset = r; stall = st; flush = fl;
    if (r || fl) begin
      nxt = '0;
    end else if (st) begin
      nxt = exp_slot;
    end else begin
      nxt = din;
      if (din.valid !== 1'b1) nxt = din & ~CTRL_MASK;
      if (din.rd == 5'd0) nxt.regwrite = 1'b0;
    end
    if (r) exp_cnt = 0;
    else if ((fl || (!st && din.valid !== 1'b1)) && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
    exp_slot = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    din = '1;
    step(1'b1, 1'b1, 1'b1);
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 0", obs);
    end
    vectors++;
    if (ValidE !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid got %b want 0", ValidE);
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    vectors++;
    if (BubbleCntE !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_bubble_cnt got %h want 0", BubbleCntE);
    end
`endif
  endtask

  task automatic test_load();
    din = rand_slot();
    din.valid = 1'b1; din.regwrite = 1'b1; din.rd = 5'd5; din.rd1 = 32'h1234_5678;
    step(1'b0, 1'b0, 1'b0);
    vectors++;
    if ({RegWriteE, RdE, RD1E, ValidE} !== {1'b1, 5'd5, 32'h1234_5678, 1'b1}) begin
      miscompares++;
      $display("FAIL load_basic got rw=%b rd=%0d rd1=%h v=%b want rw=1 rd=5 rd1=12345678 v=1",
               RegWriteE, RdE, RD1E, ValidE);
    end
    vectors++;
    if (obs !== exp_slot) begin
      miscompares++;
      $display("FAIL load_all got %h want %h", obs, exp_slot);
    end
  endtask

  task automatic test_stall();
    slot_t held;
    int unsigned cnt_before;
    din = rand_slot();
    din.valid = 1'b1; din.load = 1'b1; din.resultsrc = 2'b01; din.rd = 5'd9;
    step(1'b0, 1'b0, 1'b0);
    vectors++;
    if ({loadE, ResultSrcE, ValidE} !== {1'b1, 2'b01, 1'b1}) begin
      miscompares++;
      $display("FAIL stall_lw_load got load=%b rs=%b v=%b want 1 01 1", loadE, ResultSrcE, ValidE);
    end
    held = exp_slot;
    cnt_before = exp_cnt;
    for (int i = 0; i < 3; i++) begin
      din = rand_slot();
      step(1'b0, 1'b1, 1'b0);
      vectors++;
      if (obs !== held) begin
        miscompares++;
        $display("FAIL stall_hold[%0d] got %h want %h", i, obs, held);
      end
`ifdef ID_EX_BUBBLE_CNT_EN
      vectors++;
      if (BubbleCntE !== cnt_before) begin
        miscompares++;
        $display("FAIL stall_cnt[%0d] got %0d want %0d", i, BubbleCntE, cnt_before);
      end
`endif
    end
  endtask

  task automatic test_stall_flush();
    int unsigned cnt_before;
    din = rand_slot();
    din.valid = 1'b1; din.regwrite = 1'b1; din.memwrite = 1'b1; din.rd = 5'd3;
    step(1'b0, 1'b0, 1'b0);
    cnt_before = exp_cnt;
    din = rand_slot();
    step(1'b0, 1'b1, 1'b1);
    vectors++;
    if ((obs & CTRL_MASK) !== '0 || ValidE !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_flush got ctrl=%h v=%b want 0 0", obs & CTRL_MASK, ValidE);
    end
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL stall_flush_all got %h want 0", obs);
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    vectors++;
    if (BubbleCntE !== cnt_before + 1) begin
      miscompares++;
      $display("FAIL stall_flush_cnt got %0d want %0d", BubbleCntE, cnt_before + 1);
    end
`endif
  endtask

  task automatic test_x0_and_bubble();
    din = rand_slot();
    din.valid = 1'b1; din.regwrite = 1'b1; din.rd = 5'd0;
    step(1'b0, 1'b0, 1'b0);
    vectors++;
    if ({RegWriteE, ValidE} !== 2'b01) begin
      miscompares++;
      $display("FAIL x0_write got rw=%b v=%b want rw=0 v=1", RegWriteE, ValidE);
    end
    din = rand_slot();
    din.valid = 1'b0;
    {din.regwrite, din.memwrite, din.branch, din.jump, din.alusrc, din.load, din.jarl,
     din.resultsrc, din.aluctl} = 'x;
    din.rd = 5'd7;
    step(1'b0, 1'b0, 1'b0);
    vectors++;
    if ((obs & CTRL_MASK) !== '0 || ValidE !== 1'b0 || $isunknown(obs)) begin
      miscompares++;
      $display("FAIL bubble_x got ctrl=%h v=%b want 0 0", obs & CTRL_MASK, ValidE);
    end
    vectors++;
    if (RdE !== 5'd7 || RD1E !== din.rd1) begin
      miscompares++;
      $display("FAIL bubble_data got rd=%0d rd1=%h want 7 %h", RdE, RD1E, din.rd1);
    end
  endtask

  task automatic test_reset_priority();
    din = rand_slot();
    din.valid = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_prio got %h want 0", obs);
    end
    din = rand_slot();
    din.valid = 1'b1; din.rd = 5'd12;
    step(1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs !== exp_slot || ValidE !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_load got %h want %h", obs, exp_slot);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      din = rand_slot();
      step($urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      vectors++;
      if (obs !== exp_slot) begin
        miscompares++;
        $display("FAIL random[%0d] got %h want %h", i, obs, exp_slot);
      end
`ifdef ID_EX_BUBBLE_CNT_EN
      vectors++;
      if (BubbleCntE !== exp_cnt) begin
        miscompares++;
        $display("FAIL random_cnt[%0d] got %0d want %0d", i, BubbleCntE, exp_cnt);
      end
`endif
    end
  endtask

`ifdef ID_EX_BUBBLE_CNT_EN
  task automatic test_saturation();
    @(negedge clk);
    dut.bubble_cnt_q = 32'hFFFF_FFFE;
    exp_cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      din = rand_slot();
      step(1'b0, 1'b0, 1'b1);
      vectors++;
      if (BubbleCntE !== 32'hFFFF_FFFF) begin
        miscompares++;
        $display("FAIL saturate[%0d] got %h want ffffffff", i, BubbleCntE);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; din = '0;
    exp_slot = '0; exp_cnt = 0;
    @(negedge clk);
    test_reset();
    test_load();
    test_stall();
    test_stall_flush();
    test_x0_and_bubble();
    test_reset_priority();
    test_random();
`ifdef ID_EX_BUBBLE_CNT_EN
    test_saturation();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter XLEN, default 32, datapath width of all register-value and address fields.
REQ-002 clk  input  1  single clock; every register updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 StallE  input  1  hold: EX register keeps its current contents.
REQ-005 FlushE  input  1  squash: a bubble is loaded into the EX register.
REQ-006 ValidD  input  1  decode slot holds a real instruction.
REQ-007 RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD, loadD, jarlD  input  1 each  main-decoder control bits.
REQ-008 ResultSrcD  input  2  writeback mux select.
REQ-009 ALUControlD  input  3  ALU operation from the ALU decoder.
REQ-010 RD1D, RD2D, PCD, ImmExtD, PCPlus4D  input  XLEN each  operands, PC, extended immediate, PC+4.
REQ-011 Rs1D, Rs2D, RdD  input  5 each  register indices.
REQ-012 Each D-suffixed input in REQ-007..REQ-011 SHALL have an E-suffixed output of equal width carrying its registered value.
REQ-013 ValidE  output  1  EX slot holds a real instruction.
REQ-014 BubbleCntE  output  32  bubbles inserted into EX; present only per REQ-027.

Function
REQ-015 Update priority SHALL be reset > FlushE > StallE > load, evaluated each rising edge.
REQ-016 Load: every E output SHALL take its D input one cycle later (latency 1); ValidE SHALL become ValidD.
REQ-017 ValidD=0 on a load SHALL store a bubble: all control outputs 0, ValidE 0, data and index fields still captured.
REQ-018 On load, RegWriteE SHALL be forced 0 when RdD=0 (x0 never reported as a write target).
REQ-019 Flush: all control outputs, ValidE, Rs1E, Rs2E, RdE SHALL be 0; XLEN data fields SHALL be 0.
REQ-020 Stall without flush: every output SHALL hold its value; StallE never creates or removes an instruction.
REQ-021 FlushE and StallE asserted together: flush SHALL win; the bubble replaces the held instruction.
REQ-022 Control outputs SHALL never be X after reset, even when decoder drives X for an unimplemented opcode with ValidD=0.
REQ-023 No combinational path from any input to any output.

Reset
REQ-024 Reset SHALL clear every output, including ValidE and BubbleCntE, to 0 on the next rising edge.
REQ-025 Reset asserted mid-stall or with FlushE SHALL take precedence; the first edge after reset deasserts performs a normal load.
REQ-026 Register contents before the first reset edge are unspecified; no output is required valid then.

Configuration
REQ-027 Macro ID_EX_BUBBLE_CNT_EN: when defined, BubbleCntE SHALL exist and increment by 1 on every edge that loads a bubble (FlushE=1, or load with ValidD=0), saturating at 32'hFFFF_FFFF and holding during stall-only cycles; when undefined, the port and counter SHALL not exist and all other behaviour is identical.

Verification
REQ-028 reset=1 one edge with all inputs 1 -> all outputs 0, ValidE=0, BubbleCntE=0.
REQ-029 ValidD=1, RegWriteD=1, RdD=5, RD1D=32'h1234_5678, StallE=FlushE=0 -> next edge RegWriteE=1, RdE=5, RD1E=32'h1234_5678, ValidE=1.
REQ-030 Load lw (loadD=1, ResultSrcD=01), then StallE=1 for 3 edges with D inputs changed -> E outputs unchanged all 3 edges, BubbleCntE unchanged.
REQ-031 StallE=1 and FlushE=1 same edge with valid instruction held -> ValidE=0, all controls 0, BubbleCntE +1.
REQ-032 ValidD=1, RegWriteD=1, RdD=0 -> RegWriteE=0, ValidE=1; then ValidD=0 with X controls -> controls 0, ValidE=0, no X.
REQ-033 With ID_EX_BUBBLE_CNT_EN, counter preloaded to 32'hFFFF_FFFE, two flushes -> 32'hFFFF_FFFF both edges after the second; rebuild without macro -> REQ-028..REQ-032 pass unchanged.
